// File: rtl/cardinal_pkg.sv
// Shared packet layout, port indices and field helpers for the cardinal router.
package cardinal_pkg;
    localparam int PKT_W   = 64;
    localparam int VC_BIT  = 0;
    localparam int DIR_BIT = 1;
    localparam int HOP_MSB = 8;
    localparam int HOP_LSB = 15;

    localparam int CW    = 0;
    localparam int CCW   = 1;
    localparam int PE    = 2;
    localparam int NPORT = 3;
    localparam int NVC   = 2;

    // Bit 0 is the leftmost (VC) bit of the packet.
    typedef logic [0:PKT_W-1] pkt_t;

    function automatic logic [7:0] hop_of(pkt_t p);
        return p[HOP_MSB:HOP_LSB];
    endfunction

    function automatic pkt_t dec_hop(pkt_t p);
        pkt_t r;
        r = p;
        r[HOP_MSB:HOP_LSB] = p[HOP_MSB:HOP_LSB] - 8'd1;
        return r;
    endfunction
endpackage

// File: rtl/cardinal_router_if.sv
// Link bundle of the cardinal router: three inputs, three outputs, phase flag.
interface cardinal_router_if;
    import cardinal_pkg::*;

    logic polarity;
    logic cwsi, ccwsi, pesi;
    logic cwri, ccwri, peri;
    pkt_t cwdi, ccwdi, pedi;
    logic cwso, ccwso, peso;
    logic cwro, ccwro, pero;
    pkt_t cwdo, ccwdo, pedo;

    // Environment side (upstream senders, downstream receivers, NIC).
    modport master (
        input  polarity,
        output cwsi, ccwsi, pesi,
        input  cwri, ccwri, peri,
        output cwdi, ccwdi, pedi,
        input  cwso, ccwso, peso,
        output cwro, ccwro, pero,
        input  cwdo, ccwdo, pedo
    );

    // Router side.
    modport slave (
        output polarity,
        input  cwsi, ccwsi, pesi,
        output cwri, ccwri, peri,
        input  cwdi, ccwdi, pedi,
        output cwso, ccwso, peso,
        input  cwro, ccwro, pero,
        output cwdo, ccwdo, pedo
    );
endinterface

// File: rtl/cardinal_rr_arb2.sv
// Two-requester round-robin arbiter; priority toggles whenever a grant is used.
module cardinal_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic prio;

    // Grant requester 0 unless requester 1 holds priority and is asking.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!prio || !req[1])) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    // Priority flop; reset favours requester 0 (the ring input).
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= ~prio;
        end
    end
endmodule

// File: rtl/cardinal_router.sv
// Bidirectional ring router with PE port and two VCs; even/odd link phases.
module cardinal_router
    import cardinal_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    cardinal_router_if.slave bus
);
    logic       polarity;
    logic       si       [NPORT];
    logic       ro       [NPORT];
    pkt_t       di       [NPORT];
    logic       ri       [NPORT];
    logic       so       [NPORT];
    pkt_t       dout     [NPORT];
    logic       capture  [NPORT];
    pkt_t       in_buf   [NPORT][NVC];
    logic       in_full  [NPORT][NVC];
    pkt_t       out_buf  [NPORT][NVC];
    logic       out_full [NPORT][NVC];
    logic [1:0] arb_req  [NPORT][NVC];
    logic [1:0] arb_gnt  [NPORT][NVC];
    logic       taken    [NPORT][NVC];
    logic       load     [NPORT][NVC];
    pkt_t       ld_data  [NPORT][NVC];

    assign si[CW]  = bus.cwsi;
    assign si[CCW] = bus.ccwsi;
    assign si[PE]  = bus.pesi;
    assign ro[CW]  = bus.cwro;
    assign ro[CCW] = bus.ccwro;
    assign ro[PE]  = bus.pero;
    assign di[CW]  = bus.cwdi;
    assign di[CCW] = bus.ccwdi;
    assign di[PE]  = bus.pedi;

    assign bus.polarity = polarity;
    assign bus.cwri     = ri[CW];
    assign bus.ccwri    = ri[CCW];
    assign bus.peri     = ri[PE];
    assign bus.cwso     = so[CW];
    assign bus.ccwso    = so[CCW];
    assign bus.peso     = so[PE];
    assign bus.cwdo     = dout[CW];
    assign bus.ccwdo    = dout[CCW];
    assign bus.pedo     = dout[PE];

    // Link handshake: only the VC matching the current polarity is visible.
    always_comb begin
        for (int x = 0; x < NPORT; x++) begin
            ri[x]      = ~reset & ~in_full[x][polarity];
            so[x]      = ~reset & out_full[x][polarity] & ro[x];
            dout[x]    = out_buf[x][polarity];
            capture[x] = si[x] & ri[x] & (di[x][VC_BIT] == polarity);
        end
    end

    // Internal crossbar per VC; active only while the links serve the other VC.
    for (genvar v = 0; v < NVC; v++) begin : g_vc
        localparam logic VC_ID = (v == 1);
        logic active;
        logic cw_fwd, cw_eject, ccw_fwd, ccw_eject, pe_to_cw, pe_to_ccw;

        assign active    = (polarity != VC_ID);
        assign cw_fwd    = in_full[CW][v] & (hop_of(in_buf[CW][v]) != 8'd0);
        assign cw_eject  = in_full[CW][v] & (hop_of(in_buf[CW][v]) == 8'd0);
        assign ccw_fwd   = in_full[CCW][v] & (hop_of(in_buf[CCW][v]) != 8'd0);
        assign ccw_eject = in_full[CCW][v] & (hop_of(in_buf[CCW][v]) == 8'd0);
        assign pe_to_cw  = in_full[PE][v] & ~in_buf[PE][v][DIR_BIT];
        assign pe_to_ccw = in_full[PE][v] & in_buf[PE][v][DIR_BIT];

        // Requester 0 is always the ring input (cw input for the PE output).
        assign arb_req[CW][v]  = (active && !out_full[CW][v])  ? {pe_to_cw, cw_fwd}      : 2'b00;
        assign arb_req[CCW][v] = (active && !out_full[CCW][v]) ? {pe_to_ccw, ccw_fwd}    : 2'b00;
        assign arb_req[PE][v]  = (active && !out_full[PE][v])  ? {ccw_eject, cw_eject}   : 2'b00;

        assign taken[CW][v]  = arb_gnt[CW][v][0] | arb_gnt[PE][v][0];
        assign taken[CCW][v] = arb_gnt[CCW][v][0] | arb_gnt[PE][v][1];
        assign taken[PE][v]  = arb_gnt[CW][v][1] | arb_gnt[CCW][v][1];

        assign ld_data[CW][v]  = arb_gnt[CW][v][0]  ? dec_hop(in_buf[CW][v])  : in_buf[PE][v];
        assign ld_data[CCW][v] = arb_gnt[CCW][v][0] ? dec_hop(in_buf[CCW][v]) : in_buf[PE][v];
        assign ld_data[PE][v]  = arb_gnt[PE][v][0]  ? in_buf[CW][v]           : in_buf[CCW][v];

        for (genvar y = 0; y < NPORT; y++) begin : g_out
            assign load[y][v] = |arb_gnt[y][v];

            cardinal_rr_arb2 u_arb (
                .clk     (clk),
                .reset   (reset),
                .req     (arb_req[y][v]),
                .advance (load[y][v]),
                .gnt     (arb_gnt[y][v])
            );
        end
    end

    // Phase flag and all buffer state; captures and drains never share a VC in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            polarity <= 1'b0;
            for (int x = 0; x < NPORT; x++) begin
                for (int v = 0; v < NVC; v++) begin
                    in_buf[x][v]   <= '0;
                    in_full[x][v]  <= 1'b0;
                    out_buf[x][v]  <= '0;
                    out_full[x][v] <= 1'b0;
                end
            end
        end else begin
            polarity <= ~polarity;
            for (int x = 0; x < NPORT; x++) begin
                for (int v = 0; v < NVC; v++) begin
                    if (capture[x] && (v == int'(polarity))) begin
                        in_buf[x][v]  <= di[x];
                        in_full[x][v] <= 1'b1;
                    end else if (taken[x][v]) begin
                        in_full[x][v] <= 1'b0;
                    end
                    if (load[x][v]) begin
                        out_buf[x][v]  <= ld_data[x][v];
                        out_full[x][v] <= 1'b1;
                    end else if (so[x] && (v == int'(polarity))) begin
                        out_full[x][v] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cardinal_router.sv
// Directed bench for cardinal_router with per-output scoreboard queues.
module tb_cardinal_router;
    import cardinal_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cardinal_router_if bus ();

    cardinal_router dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    pkt_t q_cw[$];
    pkt_t q_ccw[$];
    pkt_t q_pe[$];

    function automatic pkt_t mk(bit vc, bit dir, logic [7:0] hop, logic [31:0] pay);
        pkt_t p;
        p          = '0;
        p[0]       = vc;
        p[1]       = dir;
        p[2:7]     = 6'h2A;
        p[8:15]    = hop;
        p[16:31]   = 16'hA5C3;
        p[32:63]   = pay;
        return p;
    endfunction

    task automatic check_n(string tag, int obs, int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_bit(string tag, logic obs, logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_port(int p, logic s, pkt_t d);
        pkt_t exp;
        bit   have;
        if (s !== 1'b1) return;
        have = 0;
        exp  = '0;
        case (p)
            CW:  if (q_cw.size() > 0)  begin exp = q_cw.pop_front();  have = 1; end
            CCW: if (q_ccw.size() > 0) begin exp = q_ccw.pop_front(); have = 1; end
            default: if (q_pe.size() > 0) begin exp = q_pe.pop_front(); have = 1; end
        endcase
        n_total++;
        assert (have && (d === exp)) n_pass++;
        else $error("FAIL out_port%0d observed=%h expected=%h queued=%0d", p, d, exp, have);
    endtask

    // Output monitor, sampled mid-cycle after stimulus has settled.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            chk_port(CW,  bus.cwso,  bus.cwdo);
            chk_port(CCW, bus.ccwso, bus.ccwdo);
            chk_port(PE,  bus.peso,  bus.pedo);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_in(int p, logic v, pkt_t d);
        case (p)
            CW:      begin bus.cwsi  = v; bus.cwdi  = d; end
            CCW:     begin bus.ccwsi = v; bus.ccwdi = d; end
            default: begin bus.pesi  = v; bus.pedi  = d; end
        endcase
    endtask

    task automatic set_ro(logic v);
        bus.cwro  = v;
        bus.ccwro = v;
        bus.pero  = v;
    endtask

    task automatic wait_pol(logic v);
        if (bus.polarity !== v) tick();
        check_bit("pol_align", bus.polarity, v);
    endtask

    function automatic int ri3();
        return int'({bus.cwri, bus.ccwri, bus.peri});
    endfunction

    function automatic int so3();
        return int'({bus.cwso, bus.ccwso, bus.peso});
    endfunction

    initial begin
        pkt_t a, b, c;

        set_in(CW, 1'b0, '0);
        set_in(CCW, 1'b0, '0);
        set_in(PE, 1'b0, '0);
        set_ro(1'b1);

        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        check_bit("rst_pol", bus.polarity, 1'b0);
        check_n("rst_so", so3(), 0);
        check_n("rst_ri", ri3(), 0);
        reset = 1'b0;
        #1;
        check_n("ri_after_rst", ri3(), 7);
        check_bit("pol_first", bus.polarity, 1'b0);

        // PE inject, dir cw, VC0: leaves on cw output one phase pair later, once.
        a = mk(1'b0, 1'b0, 8'd2, 32'h1111_2222);
        q_cw.push_back(a);
        set_in(PE, 1'b1, a);
        tick();
        set_in(PE, 1'b0, '0);
        check_bit("pol_toggle", bus.polarity, 1'b1);
        check_bit("pe_inj_early", bus.cwso, 1'b0);
        tick();
        check_bit("pe_inj_send", bus.cwso, 1'b1);
        tick();
        check_bit("pe_inj_once_a", bus.cwso, 1'b0);
        tick();
        check_bit("pe_inj_once_b", bus.cwso, 1'b0);

        // cw input, hop 0, VC1: ejected unchanged to PE.
        wait_pol(1'b1);
        check_bit("cw_vc1_ready", bus.cwri, 1'b1);
        a = mk(1'b1, 1'b0, 8'd0, 32'hDEAD_BEEF);
        q_pe.push_back(a);
        set_in(CW, 1'b1, a);
        tick();
        set_in(CW, 1'b0, '0);
        check_bit("eject_early", bus.peso, 1'b0);
        tick();
        check_bit("eject_send", bus.peso, 1'b1);
        tick();

        // Contention for cw output VC1: cw input wins, then PE, then PE beats a new cw packet.
        wait_pol(1'b1);
        a = mk(1'b1, 1'b0, 8'd3, 32'hA000_0001);
        b = mk(1'b1, 1'b0, 8'd5, 32'hB000_0002);
        q_cw.push_back(mk(1'b1, 1'b0, 8'd2, 32'hA000_0001));
        q_cw.push_back(b);
        set_in(CW, 1'b1, a);
        set_in(PE, 1'b1, b);
        tick();
        set_in(CW, 1'b0, '0);
        set_in(PE, 1'b0, '0);
        tick();
        check_bit("arb_first_send", bus.cwso, 1'b1);
        check_bit("arb_cw_free", bus.cwri, 1'b1);
        c = mk(1'b1, 1'b0, 8'd4, 32'hC000_0003);
        q_cw.push_back(mk(1'b1, 1'b0, 8'd3, 32'hC000_0003));
        set_in(CW, 1'b1, c);
        tick();
        set_in(CW, 1'b0, '0);
        repeat (6) tick();
        check_n("arb_drained", q_cw.size(), 0);

        // Backpressure on cw output VC0 for ten cycles, then ordered drain.
        set_ro(1'b0);
        bus.cwro = 1'b0;
        wait_pol(1'b0);
        set_in(CW, 1'b1, mk(1'b0, 1'b0, 8'd1, 32'h0000_0011));
        q_cw.push_back(mk(1'b0, 1'b0, 8'd0, 32'h0000_0011));
        tick();
        set_in(CW, 1'b0, '0);
        tick();
        check_bit("bp_ri_second", bus.cwri, 1'b1);
        set_in(CW, 1'b1, mk(1'b0, 1'b0, 8'd2, 32'h0000_0022));
        q_cw.push_back(mk(1'b0, 1'b0, 8'd1, 32'h0000_0022));
        tick();
        set_in(CW, 1'b0, '0);
        tick();
        check_bit("bp_ri_full", bus.cwri, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_bit("bp_no_send", bus.cwso, 1'b0);
        end
        check_bit("bp_ri_still_full", bus.cwri, 1'b0);
        set_ro(1'b1);
        for (int i = 0; i < 8; i++) begin
            if (bus.cwri && !bus.polarity) break;
            tick();
        end
        check_bit("bp_ri_recover", bus.cwri, 1'b1);
        check_bit("bp_ri_phase", bus.polarity, 1'b0);
        set_in(CW, 1'b1, mk(1'b0, 1'b0, 8'd3, 32'h0000_0033));
        q_cw.push_back(mk(1'b0, 1'b0, 8'd2, 32'h0000_0033));
        tick();
        set_in(CW, 1'b0, '0);
        repeat (6) tick();
        check_n("bp_drained", q_cw.size(), 0);

        // Wrong-VC send is ignored and leaves ready untouched.
        wait_pol(1'b0);
        set_in(CW, 1'b1, mk(1'b1, 1'b0, 8'd1, 32'hBAD0_BAD0));
        #1;
        check_bit("wrongvc_ri_a", bus.cwri, 1'b1);
        tick();
        set_in(CW, 1'b0, '0);
        check_bit("wrongvc_ri_b", bus.cwri, 1'b1);
        tick();
        check_bit("wrongvc_ri_c", bus.cwri, 1'b1);
        repeat (4) tick();

        // Fill all twelve buffers with outputs stalled, then reset.
        set_ro(1'b0);
        wait_pol(1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 2; v++) begin
                if (r == 1) check_n("fill_ri_open", ri3(), 7);
                set_in(CW,  1'b1, mk(v[0], 1'b0, 8'd0, 32'h100 + 32'(r * 2 + v)));
                set_in(CCW, 1'b1, mk(v[0], 1'b1, 8'd1, 32'h200 + 32'(r * 2 + v)));
                set_in(PE,  1'b1, mk(v[0], 1'b0, 8'd4, 32'h300 + 32'(r * 2 + v)));
                tick();
            end
        end
        set_in(CW, 1'b0, '0);
        set_in(CCW, 1'b0, '0);
        set_in(PE, 1'b0, '0);
        check_n("fill_ri_vc0", ri3(), 0);
        tick();
        check_n("fill_ri_vc1", ri3(), 0);
        reset = 1'b1;
        set_ro(1'b1);
        #1;
        check_n("rst_mid_so", so3(), 0);
        check_n("rst_mid_ri", ri3(), 0);
        tick();
        check_n("rst_next_so", so3(), 0);
        check_bit("rst_next_pol", bus.polarity, 1'b0);
        reset = 1'b0;
        #1;
        check_n("rst_rel_ri", ri3(), 7);
        check_bit("rst_rel_pol", bus.polarity, 1'b0);
        repeat (6) tick();
        check_n("end_queues", q_cw.size() + q_ccw.size() + q_pe.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
